mult_div_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the register bank. It consumes readData1/readData2 as operands and executes MULT, MULTU, DIV and DIVU into HI/LO registers. It also serves mfhi/mflo reads and mthi/mtlo writes. A start/busy/done handshake lets the pipeline control stall while an operation is in flight.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 114 +++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  // Cycles from the start edge to the cycle in which done is high.
  localparam int LATENCY = MDU_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mduOp_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } mduState_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/command and HI/LO result bundle of the multiply/divide unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             hiWrite;
  logic             loWrite;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operandA, operandB, hiWrite, loWrite,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, operandA, operandB, hiWrite, loWrite,
    output busy, done, divByZero, hi, lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU into HI/LO with mthi/mtlo access
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  mduState_t          state, stateNext;
  logic               divOp;
  logic               negRes;
  logic               negRem;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               divByZeroReg;

  logic               launch, isSigned, isDiv, bZero, subtract;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     addLhs, addRhs, addSum;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign isSigned = ~bus.op[0];
  assign isDiv    = bus.op[1];
  assign bZero    = (bus.operandB == '0);
  assign launch   = (state == IDLE) && bus.start;
  assign magA     = (isSigned && bus.operandA[WIDTH-1]) ? -bus.operandA : bus.operandA;
  assign magB     = (isSigned && bus.operandB[WIDTH-1]) ? -bus.operandB : bus.operandB;

  // One adder serves both loops: add multiplicand in MUL, trial-subtract divisor in DIV.
  assign subtract = (state == DIV);
  assign addLhs   = subtract ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign addRhs   = subtract ? ~{1'b0, operand} : {1'b0, operand};
  assign addSum   = addLhs + addRhs + {{WIDTH{1'b0}}, subtract};

  assign prodFix  = negRes ? -acc : acc;
  assign quoFix   = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix   = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (bus.start) stateNext = isDiv ? (bZero ? FIX : DIV) : MUL;
      MUL:  if (cnt == CW'(WIDTH-1)) stateNext = FIX;
      DIV:  if (cnt == CW'(WIDTH-1)) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divOp        <= 1'b0;
      negRes       <= 1'b0;
      negRem       <= 1'b0;
      operand      <= '0;
      acc          <= '0;
      cnt          <= '0;
      hiReg        <= '0;
      loReg        <= '0;
      divByZeroReg <= 1'b0;
    end else begin
      if (launch) begin
        divOp        <= isDiv;
        cnt          <= '0;
        divByZeroReg <= isDiv && bZero;
        if (isDiv && bZero) begin
          // Preloading the fixed result lets FIX pass it through untouched.
          negRes  <= 1'b0;
          negRem  <= 1'b0;
          operand <= '0;
          acc     <= {bus.operandA, {WIDTH{1'b1}}};
        end else begin
          negRes  <= isSigned && (bus.operandA[WIDTH-1] ^ bus.operandB[WIDTH-1]);
          negRem  <= isSigned && bus.operandA[WIDTH-1];
          operand <= isDiv ? magB : magA;
          acc     <= {{WIDTH{1'b0}}, isDiv ? magA : magB};
        end
      end else if (state == IDLE) begin
        if (bus.hiWrite) hiReg <= bus.operandA;
        if (bus.loWrite) loReg <= bus.operandA;
      end else if (state == MUL) begin
        acc <= acc[0] ? {addSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        cnt <= cnt + CW'(1);
      end else if (state == DIV) begin
        acc <= addSum[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {addSum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        cnt <= cnt + CW'(1);
      end else if (state == FIX) begin
        {hiReg, loReg} <= divOp ? {remFix, quoFix} : prodFix;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.divByZero = divByZeroReg;
  assign bus.hi        = hiReg;
  assign bus.lo        = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = MDU_WIDTH;

  typedef struct {
    mduOp_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          nCompared = 0;
  int          nMismatch = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;
  exp_t        sbq[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refModel(input mduOp_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rHi, output logic [31:0] rLo);
    longint sa, sb, sp;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; {rHi, rLo} = up; end
      OP_MULT:  begin sp = sa * sb; {rHi, rLo} = sp; end
      OP_DIVU:  begin rLo = a / b; rHi = a % b; end
      default:  begin sp = sa / sb; rLo = sp[31:0]; sp = sa % sb; rHi = sp[31:0]; end
    endcase
  endtask

  task automatic runOp(input mduOp_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo, input logic expDbz,
                       input int restartAt, input int loWrAt, input logic hiWrAtStart);
    exp_t e;
    int   lat;
    logic stable, busyOk;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operandA = a; bus.operandB = b;
    bus.hiWrite = hiWrAtStart; bus.loWrite = 1'b0;
    e.hi = expHi; e.lo = expLo; e.dbz = expDbz;
    e.lat = (op[1] && b == 0) ? 2 : LATENCY;
    sbq.push_back(e);
    lat = 0; stable = 1'b1; busyOk = 1'b1;
    for (int k = 1; k <= LATENCY + 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
      bus.operandA = $urandom; bus.operandB = $urandom;
      if (bus.done) begin lat = k; break; end
      if (!bus.busy) busyOk = 1'b0;
      if (bus.hi !== modelHi || bus.lo !== modelLo) stable = 1'b0;
      if (k == 1 && !expDbz) check("dbzClearedOnStart", bus.divByZero, 0);
      if (k == restartAt) begin
        bus.start = 1'b1; bus.op = OP_MULTU; bus.operandA = 9; bus.operandB = 9;
      end
      if (k == loWrAt) begin bus.loWrite = 1'b1; bus.operandA = 32'hDEAD; end
    end
    e = sbq.pop_front();
    check("latency", lat, e.lat);
    check("busyDuringOp", busyOk, 1);
    check("hiloStableWhileBusy", stable, 1);
    check("busyAtDone", bus.busy, 1);
    check("hi", bus.hi, e.hi);
    check("lo", bus.lo, e.lo);
    check("divByZero", bus.divByZero, e.dbz);
    modelHi = e.hi; modelLo = e.lo;
    @(negedge clk);
    check("busyAfterDone", bus.busy, 0);
    check("donePulseWidth", bus.done, 0);
  endtask

  task automatic regWrite(input logic toHi, input logic [31:0] val);
    @(negedge clk);
    bus.hiWrite = toHi; bus.loWrite = !toHi; bus.operandA = val;
    @(negedge clk);
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    if (toHi) modelHi = val; else modelLo = val;
    check("mtHiLoHi", bus.hi, modelHi);
    check("mtHiLoLo", bus.lo, modelLo);
  endtask

  initial begin
    logic [31:0] ra, rb, rh, rl;
    mduOp_t      rop;
    logic        sawDone;

    bus.start = 1'b0; bus.op = OP_MULT; bus.operandA = '0; bus.operandB = '0;
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    repeat (3) @(negedge clk);
    check("rstBusy", bus.busy, 0);
    check("rstDone", bus.done, 0);
    check("rstDbz", bus.divByZero, 0);
    check("rstHi", bus.hi, 0);
    check("rstLo", bus.lo, 0);
    rst_n = 1'b1;

    vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{OP_DIVU,  32'd12,       32'd0,        32'd12,       32'hFFFFFFFF, 1'b1});
    vecs.push_back('{OP_MULTU, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
    vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{OP_DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        1'b0});
    vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});

    foreach (vecs[i])
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].expDbz,
            0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = mduOp_t'(i % 4);
      ra  = $urandom;
      rb  = $urandom;
      if (rop[1] && (rb == 0 || (rb == 32'hFFFFFFFF && ra == 32'h80000000))) rb = 32'd3;
      refModel(rop, ra, rb, rh, rl);
      runOp(rop, ra, rb, rh, rl, 1'b0, 0, 0, 1'b0);
    end

    runOp(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 5, 10, 1'b0);
    regWrite(1'b1, 32'h1234);
    regWrite(1'b0, 32'h5678);
    runOp(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0, 0, 1'b1);
    regWrite(1'b1, 32'h00AB);

    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.operandA = 6; bus.operandB = 7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midRstHi", bus.hi, 0);
    check("midRstLo", bus.lo, 0);
    check("midRstBusy", bus.busy, 0);
    check("midRstDone", bus.done, 0);
    modelHi = '0; modelLo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    check("noDoneAfterAbort", sawDone, 0);
    check("idleAfterAbort", bus.busy, 0);
    runOp(OP_DIVU, 32'd15, 32'd4, 32'd3, 32'd3, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
